// File: rtl/nvram_pkg.sv
// Shared types and helpers for the NVRAM upload path (hiscore/NVRAM save to SD).
// Optional feature macro: NVRAM_UPLOAD_CHECKSUM_EN (checksum bytes at DEPTH, DEPTH+1).
package nvram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PAUSE,
        ST_READY,
        ST_FETCH,
        ST_FILLR
    } nvram_state_e;

    localparam logic [7:0] NVRAM_IDX_HISCORE = 8'd4;

    // Byte served for an address at or beyond DEPTH; off is (addr - DEPTH).
    // With the checksum enabled the first two slots expose the running sum.
    function automatic logic [7:0] fill_byte(
        input logic        csum_en,
        input logic [24:0] off,
        input logic [15:0] sum,
        input logic [7:0]  fill
    );
        if (csum_en && off == 25'd0)
            return sum[7:0];
        else if (csum_en && off == 25'd1)
            return sum[15:8];
        return fill;
    endfunction

endpackage

// File: rtl/nvram_latency_ctr.sv
// Down-counter that times the NVRAM read latency after a read strobe.
// load is asserted in the strobe cycle; done is high once MEM_LAT-1 further
// cycles have elapsed, i.e. in the cycle where mem_dout is valid.
module nvram_latency_ctr #(
    parameter int MEM_LAT = 1
) (
    input  logic clk_sys,
    input  logic RESET_N,
    input  logic load,
    output logic done
);

    logic [2:0] cnt;

    // Reload on the read strobe, then count down to zero and hold there.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N)
            cnt <= 3'd0;
        else if (load)
            cnt <= 3'(MEM_LAT - 1);
        else if (cnt != 3'd0)
            cnt <= cnt - 3'd1;
    end

    assign done = (cnt == 3'd0);

endmodule

// File: rtl/nvram_upload.sv
// Answers HPS ioctl upload byte requests from game NVRAM: pauses the core,
// fetches each byte through a spare RAM port and holds ioctl_wait until valid.
// Optional feature macro: NVRAM_UPLOAD_CHECKSUM_EN (16-bit sum at DEPTH/DEPTH+1).
module nvram_upload
    import nvram_pkg::*;
#(
    parameter logic [7:0] INDEX   = NVRAM_IDX_HISCORE,
    parameter int         DEPTH   = 1024,
    parameter int         AW      = $clog2(DEPTH),
    parameter int         MEM_LAT = 1,
    parameter logic [7:0] FILL    = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          RESET_N,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_dout
);

    nvram_state_e state;
    logic         sel;
    logic         pend;
    logic [24:0]  req_addr;
    logic [24:0]  acc_addr;
    logic         acc_in_range;
    logic         start_req;
    logic         ctr_load;
    logic         ctr_done;
    logic         fetch_done;

    assign sel = ioctl_upload && (ioctl_index == INDEX);

    // Pick which request (live or latched during PAUSE) is accepted this cycle.
    always_comb begin
        acc_addr  = ioctl_addr;
        start_req = 1'b0;
        if (state == ST_READY) begin
            start_req = ioctl_rd;
        end else if (state == ST_PAUSE) begin
            if (pend)
                acc_addr = req_addr;
            start_req = pause_ack && (pend || ioctl_rd);
        end
    end

    // Full 25-bit compare so high addresses never alias into the RAM.
    assign acc_in_range = (acc_addr < 25'(DEPTH));

    assign ctr_load   = (state == ST_FETCH) && mem_rd;
    assign fetch_done = (state == ST_FETCH) && !mem_rd && ctr_done;

    nvram_latency_ctr #(
        .MEM_LAT (MEM_LAT)
    ) u_lat (
        .clk_sys (clk_sys),
        .RESET_N (RESET_N),
        .load    (ctr_load),
        .done    (ctr_done)
    );

`ifdef NVRAM_UPLOAD_CHECKSUM_EN
    logic [15:0] sum;

    // Running sum of in-range bytes served since this upload began.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N)
            sum <= 16'h0000;
        else if (state == ST_IDLE && sel)
            sum <= 16'h0000;
        else if (fetch_done && sel)
            sum <= sum + {8'h00, mem_dout};
    end
`endif

    // Upload control FSM: pause handshake, request acceptance, fetch and fill.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            pause_req  <= 1'b0;
            ioctl_wait <= 1'b0;
            ioctl_din  <= 8'h00;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            req_addr   <= '0;
            pend       <= 1'b0;
        end else if (state != ST_IDLE && !sel) begin
            state      <= ST_IDLE;
            pause_req  <= 1'b0;
            ioctl_wait <= 1'b0;
            mem_rd     <= 1'b0;
            pend       <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            if (start_req) begin
                req_addr   <= acc_addr;
                pend       <= 1'b0;
                ioctl_wait <= 1'b1;
                if (acc_in_range) begin
                    mem_addr <= acc_addr[AW-1:0];
                    mem_rd   <= 1'b1;
                    state    <= ST_FETCH;
                end else begin
                    state    <= ST_FILLR;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sel) begin
                            state     <= ST_PAUSE;
                            pause_req <= 1'b1;
                            pend      <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (ioctl_rd && !pend) begin
                            req_addr   <= ioctl_addr;
                            pend       <= 1'b1;
                            ioctl_wait <= 1'b1;
                        end else if (pause_ack) begin
                            state <= ST_READY;
                        end
                    end
                    ST_READY: begin
                    end
                    ST_FETCH: begin
                        if (fetch_done) begin
                            ioctl_din  <= mem_dout;
                            ioctl_wait <= 1'b0;
                            state      <= ST_READY;
                        end
                    end
                    ST_FILLR: begin
`ifdef NVRAM_UPLOAD_CHECKSUM_EN
                        ioctl_din <= fill_byte(1'b1, req_addr - 25'(DEPTH), sum, FILL);
`else
                        ioctl_din <= fill_byte(1'b0, req_addr - 25'(DEPTH), 16'h0000, FILL);
`endif
                        ioctl_wait <= 1'b0;
                        state      <= ST_READY;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
